baseline_trigger: RTL
=====================

BASELINE_TRIGGER -- requirements
Module: baseline_trigger

Interface
REQ-001 SHALL have one clock, clk, with an asynchronous active-low reset, rst_n.
REQ-002 Parameter THRESH, 14'd50: minimum excess over baseline; a sample counts as "above" only when excess > THRESH.
REQ-003 Parameter MIN_TOT, 8'd2: consecutive above samples needed to qualify a pulse; 0 is treated as 1.
REQ-004 Parameter HOLDOFF, 8'd16: dead-time cycles after a qualified pulse.
REQ-005 Port clk  in  1  system clock.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port adc  in  14  raw unsigned ADC sample, one per clock.
REQ-008 Port avr_whole  in  25  integer part of the running-average baseline from the averaging stage.
REQ-009 Port avr_frac  in  15  fractional part of the baseline.
REQ-010 Port trig  out  1  one-cycle pulse when a pulse qualifies.
REQ-011 Port busy  out  1  high whenever the FSM is not IDLE.
REQ-012 Port evt_valid  out  1  one-cycle strobe when tot and peak update.
REQ-013 Port tot  out  8  time-over-threshold of the last qualified pulse, in cycles.
REQ-014 Port peak  out  14  maximum excess of the last qualified pulse.

Function
REQ-015 Stage 1 SHALL register adc_d = adc and base every cycle:
- base = 14'h3FFF if avr_whole[24:14] != 0; otherwise avr_whole[13:0].
- base rounds up by 1 when avr_frac[14] = 1, saturating at 14'h3FFF.
REQ-016 Excess SHALL be the signed 15-bit value adc_d - base; "above" means excess is positive and exceeds THRESH; negative excess is never above.
REQ-017 The FSM SHALL have three states, IDLE, OVER and HOLD, registered in stage 2.
REQ-018 IDLE: on above, go to OVER with cnt = 1 and peak_run = excess[13:0]; otherwise stay in IDLE.
REQ-019 OVER while above:
- cnt increments, saturating at 255.
- peak_run = max(peak_run, excess).
- The baseline is re-evaluated every cycle.
REQ-020 OVER on not-above:
- If cnt >= MIN_TOT: pulse evt_valid, load tot = cnt and peak = peak_run, then go to HOLD (or to IDLE directly if HOLDOFF = 0).
- Otherwise: go to IDLE with no strobe and tot/peak unchanged.
REQ-021 trig SHALL be a registered pulse that is high for exactly one cycle, in the cycle after the edge at which cnt first reaches MIN_TOT.
- Latency: if MIN_TOT consecutive above samples are presented at edges k..k+MIN_TOT-1, trig is high in the cycle after edge k+MIN_TOT.
REQ-022 HOLD SHALL last exactly HOLDOFF cycles and then return to IDLE; above samples during HOLD are ignored.
REQ-023 evt_valid SHALL be high in the cycle after edge j+1, where j is the edge presenting the first not-above sample; tot and peak become valid in that same cycle and hold until the next event.
REQ-024 A pulse that stays above indefinitely SHALL keep the FSM in OVER, with cnt saturating at 255 and trig firing only once.

Reset
REQ-025 While rst_n = 0, all outputs SHALL read 0 (trig, busy, evt_valid, tot, peak) and the pipeline, cnt, peak_run and hold counter SHALL clear asynchronously.
REQ-026 Reset in any state, including mid-OVER, SHALL return the FSM to IDLE with no evt_valid produced for the aborted pulse; the first sample after release is stage 1 input.

Configuration
REQ-027 Macro PEAK_CAPTURE_EN:
- Defined: peak_run and the peak register are implemented per REQ-019/020.
- Undefined: peak is tied to 14'd0 and no peak logic is built; all other behaviour is unchanged.

Verification (THRESH=50, MIN_TOT=2, HOLDOFF=16, avr_whole=1000, avr_frac=0 unless stated)
REQ-028 adc = 1000 for 100 cycles -> trig, evt_valid and busy remain 0.
REQ-029 adc = 1100 for 5 cycles (starting at edge k), then 1000 -> trig high only in the cycle after edge k+2; evt_valid with tot = 5 and peak = 100 (0 without PEAK_CAPTURE_EN); busy high for 5 + 16 cycles.
REQ-030 A single adc = 1200 sample -> busy high for 1 cycle, with no trig and no evt_valid.
REQ-031 A second 1100 pulse starting 3 cycles after the first pulse's evt_valid -> ignored, with no second trig.
REQ-032 Saturation and rounding:
- avr_whole = 25'h100000 with adc = 14'h3FFF -> no trigger.
- avr_whole = 999 with avr_frac = 15'h4000 -> base = 1000; adc = 1050 is not above and adc = 1051 is above.
REQ-033 rst_n asserted on the 3rd cycle of an OVER run -> all outputs 0 immediately; after release, no evt_valid for the aborted pulse.

Source files
------------

// File: rtl/baseline_trigger.sv
// Baseline-subtracting pulse trigger: stage 1 registers the sample and baseline, stage 2 runs the pulse FSM.
// Optional macro PEAK_CAPTURE_EN builds the per-pulse peak tracker; without it, peak reads 0.
module baseline_trigger #(
    parameter logic [13:0] THRESH  = 14'd50,
    parameter logic [7:0]  MIN_TOT = 8'd2,
    parameter logic [7:0]  HOLDOFF = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] adc,
    input  logic [24:0] avr_whole,
    input  logic [14:0] avr_frac,
    output logic        trig,
    output logic        busy,
    output logic        evt_valid,
    output logic [7:0]  tot,
    output logic [13:0] peak
);

    localparam logic [7:0] MIN_EFF = (MIN_TOT == 8'd0) ? 8'd1 : MIN_TOT;

    typedef enum logic [1:0] {IDLE, OVER, HOLD} state_t;

    function automatic logic [13:0] f_round_base(input logic [24:0] whole, input logic frac_msb);
        logic [13:0] b;
        b = (|whole[24:14]) ? 14'h3FFF : whole[13:0];
        if (frac_msb && (b != 14'h3FFF))
            b = b + 14'd1;
        return b;
    endfunction

    logic [13:0]        r_adc_p1;
    logic [13:0]        r_base_p1;
    logic signed [14:0] w_excess;
    logic               w_above;
    logic [7:0]         w_cnt_inc;
    logic               w_unused_frac;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_hold;
    logic        r_trig;
    logic        r_busy;
    logic        r_evt;
    logic [7:0]  r_tot;
`ifdef PEAK_CAPTURE_EN
    logic [13:0] r_peak_run;
    logic [13:0] r_peak;
`endif

    assign w_unused_frac = ^avr_frac[13:0];

    // Stage 1: sample and baseline registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_p1  <= 14'd0;
            r_base_p1 <= 14'd0;
        end else begin
            r_adc_p1  <= adc;
            r_base_p1 <= f_round_base(avr_whole, avr_frac[14]);
        end
    end

    assign w_excess  = $signed({1'b0, r_adc_p1}) - $signed({1'b0, r_base_p1});
    assign w_above   = !w_excess[14] && (w_excess[13:0] > THRESH);
    assign w_cnt_inc = (r_cnt == 8'd255) ? r_cnt : r_cnt + 8'd1;

    // Stage 2: pulse FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_hold     <= 8'd0;
            r_trig     <= 1'b0;
            r_busy     <= 1'b0;
            r_evt      <= 1'b0;
            r_tot      <= 8'd0;
`ifdef PEAK_CAPTURE_EN
            r_peak_run <= 14'd0;
            r_peak     <= 14'd0;
`endif
        end else begin
            r_trig <= 1'b0;
            r_evt  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_above) begin
                        r_state <= OVER;
                        r_cnt   <= 8'd1;
                        r_busy  <= 1'b1;
                        r_trig  <= (MIN_EFF == 8'd1);
`ifdef PEAK_CAPTURE_EN
                        r_peak_run <= w_excess[13:0];
`endif
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                OVER: begin
                    if (w_above) begin
                        r_cnt  <= w_cnt_inc;
                        r_trig <= (w_cnt_inc == MIN_EFF) && (r_cnt != MIN_EFF);
`ifdef PEAK_CAPTURE_EN
                        if (w_excess[13:0] > r_peak_run)
                            r_peak_run <= w_excess[13:0];
`endif
                    end else if (r_cnt >= MIN_EFF) begin
                        r_evt <= 1'b1;
                        r_tot <= r_cnt;
`ifdef PEAK_CAPTURE_EN
                        r_peak <= r_peak_run;
`endif
                        if (HOLDOFF == 8'd0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= HOLD;
                            r_hold  <= HOLDOFF - 8'd1;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_hold == 8'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold <= r_hold - 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign trig      = r_trig;
    assign busy      = r_busy;
    assign evt_valid = r_evt;
    assign tot       = r_tot;
`ifdef PEAK_CAPTURE_EN
    assign peak      = r_peak;
`else
    assign peak      = 14'd0;
`endif

endmodule
